// File: rtl/pinb_input_conditioner.sv
// Input conditioner for the PB2..PB5 pads feeding the tiny85 model.
// Each pad is synchronised, then debounced into a stable level. The stable
// levels form the PINB word. Stable-level changes produce per-pin pulses and a
// masked sticky pin-change flag, in the style of PCIF/PCMSK.
module pinb_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vcc,
  input  logic [3:0] pin_raw,
  input  logic [3:0] pcmsk,
  input  logic       pcif_clr,
  output logic [5:0] pinb_data,
  output logic [3:0] pin_change,
  output logic       pcif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q [4];
  logic [SYNC_STAGES-1:0] sync_d [4];
  logic [CW-1:0]          cnt_q  [4];
  logic [CW-1:0]          cnt_d  [4];
  logic [3:0]             stable_q, stable_d;
  logic [3:0]             synced;
  logic [3:0]             upd;
  logic [3:0]             pin_change_q, pin_change_d;
  logic                   pcif_q, pcif_d;

  // Next-state for sync chains, debounce counters, stable levels and flags.
  // vcc low forces everything back to its reset value on the next edge.
  always_comb begin
    stable_d     = stable_q;
    upd          = 4'b0000;
    synced       = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      sync_d[i] = '0;
      cnt_d[i]  = cnt_q[i];
      synced[i] = sync_q[i][SYNC_STAGES-1];
      if (!vcc) begin
        cnt_d[i]    = '0;
        stable_d[i] = 1'b0;
      end else begin
        sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], pin_raw[i]};
        if (synced[i] == stable_q[i]) begin
          // Agreement (or a reversal mid-count) restarts the count.
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          // New level has held long enough: accept it.
          stable_d[i] = synced[i];
          cnt_d[i]    = '0;
          upd[i]      = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end

    pin_change_d = vcc ? upd : 4'b0000;

    // Set beats clear when both happen on the same edge.
    pcif_d = pcif_q;
    if (!vcc) begin
      pcif_d = 1'b0;
    end else if (|(upd & pcmsk)) begin
      pcif_d = 1'b1;
    end else if (pcif_clr) begin
      pcif_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      stable_q     <= 4'b0000;
      pin_change_q <= 4'b0000;
      pcif_q       <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      stable_q     <= stable_d;
      pin_change_q <= pin_change_d;
      pcif_q       <= pcif_d;
    end
  end

  // PB2..PB5 land on PINB bits 2..5; bits 1:0 are unused and read 0.
  assign pinb_data  = {stable_q, 2'b00};
  assign pin_change = pin_change_q;
  assign pcif       = pcif_q;

endmodule

// File: tb/tb_pinb_input_conditioner.sv
// Self-checking bench for pinb_input_conditioner: directed scenarios followed
// by randomized pads/mask/clear/vcc/reset traffic against a sliding-window model.
module tb_pinb_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HL   = SYNC + DEB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vcc = 1'b1;
  logic       pcif_clr = 1'b0;
  logic [3:0] pin_raw = 4'h0;
  logic [3:0] pcmsk = 4'hF;
  logic [5:0] pinb_data;
  logic [3:0] pin_change;
  logic       pcif;

  always #5 clk = ~clk;

  pinb_input_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vcc       (vcc),
    .pin_raw   (pin_raw),
    .pcmsk     (pcmsk),
    .pcif_clr  (pcif_clr),
    .pinb_data (pinb_data),
    .pin_change(pin_change),
    .pcif      (pcif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: m_hist[j] is the pad word sampled j edges ago (0 = this edge).
  // A pin flips when every sample in the window that has reached the end of
  // the synchroniser over the last DEB edges disagrees with its stable level.
  logic [3:0] m_hist [HL];
  logic [3:0] m_stable;
  logic [3:0] m_chg;
  logic       m_pcif;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < HL; j++) m_hist[j] = 4'h0;
    m_stable = 4'h0;
    m_chg    = 4'h0;
    m_pcif   = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] flip;
    if (!rst_n || !vcc) begin
      model_clear();
      return;
    end
    for (int j = HL - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = pin_raw;
    flip = 4'hF;
    for (int j = SYNC; j < HL; j++) flip = flip & (m_hist[j] ^ m_stable);
    m_chg    = flip;
    m_stable = m_stable ^ flip;
    if ((flip & pcmsk) != 4'h0) m_pcif = 1'b1;
    else if (pcif_clr)          m_pcif = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".pinb"}, 32'(pinb_data),  32'({m_stable, 2'b00}));
    chk({tag, ".chg"},  32'(pin_change), 32'(m_chg));
    chk({tag, ".pcif"}, 32'(pcif),       32'(m_pcif));
  endtask

  // Called at a negedge; advances n rising edges, checking after each.
  task automatic step(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs(tag);
    end
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk({tag, ".rst_pinb"}, 32'(pinb_data),  32'h00);
    chk({tag, ".rst_chg"},  32'(pin_change), 32'h0);
    chk({tag, ".rst_pcif"}, 32'(pcif),       32'h0);
  endtask

  task automatic reset_pulse(input string tag);
    async_reset(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    // Reset and steady low
    repeat (2) @(negedge clk);
    chk("reset.pinb", 32'(pinb_data), 32'h00);
    chk("reset.chg",  32'(pin_change), 32'h0);
    chk("reset.pcif", 32'(pcif), 32'h0);
    rst_n = 1'b1;
    step(20, "steady_low");
    chk("steady_low.end", 32'(pinb_data), 32'h00);

    // Clean edge on PB3
    reset_pulse("pb3");
    pin_raw = 4'b0010;
    step(5, "pb3");
    chk("pb3.e5_pinb", 32'(pinb_data), 32'h00);
    step(1, "pb3");
    chk("pb3.e6_pinb", 32'(pinb_data), 32'h08);
    chk("pb3.e6_chg",  32'(pin_change), 32'h2);
    chk("pb3.e6_pcif", 32'(pcif), 32'h1);
    step(1, "pb3");
    chk("pb3.e7_chg",  32'(pin_change), 32'h0);

    // Glitch rejection, then a 4-cycle pulse accepted
    reset_pulse("glitch");
    pin_raw = 4'b0100;
    step(3, "glitch");
    pin_raw = 4'b0000;
    step(10, "glitch");
    chk("glitch.pinb", 32'(pinb_data), 32'h00);
    chk("glitch.pcif", 32'(pcif), 32'h0);
    pin_raw = 4'b0100;
    step(4, "pulse4");
    pin_raw = 4'b0000;
    step(3, "pulse4");
    chk("pulse4.pinb", 32'(pinb_data), 32'h10);
    step(10, "pulse4");

    // Masking and clear
    reset_pulse("mask");
    pcmsk   = 4'b0001;
    pin_raw = 4'b1000;
    step(6, "mask");
    chk("mask.pb5_pinb", 32'(pinb_data), 32'h20);
    chk("mask.pb5_chg",  32'(pin_change), 32'h8);
    chk("mask.pb5_pcif", 32'(pcif), 32'h0);
    pin_raw = 4'b0000;
    step(6, "mask");
    chk("mask.pb5_fall", 32'(pinb_data), 32'h00);
    pin_raw = 4'b0001;
    step(5, "setwins");
    pcif_clr = 1'b1;
    step(1, "setwins");
    chk("setwins.pcif", 32'(pcif), 32'h1);
    chk("setwins.pinb", 32'(pinb_data), 32'h04);
    step(1, "clear");
    chk("clear.pcif", 32'(pcif), 32'h0);
    pcif_clr = 1'b0;
    step(2, "clear");

    // Simultaneous pins
    reset_pulse("simul");
    pcmsk   = 4'hF;
    pin_raw = 4'hF;
    step(5, "simul");
    chk("simul.e5_pinb", 32'(pinb_data), 32'h00);
    step(1, "simul");
    chk("simul.e6_pinb", 32'(pinb_data), 32'h3C);
    chk("simul.e6_chg",  32'(pin_change), 32'hF);
    chk("simul.e6_pcif", 32'(pcif), 32'h1);
    step(1, "simul");
    chk("simul.e7_chg", 32'(pin_change), 32'h0);

    // Power drop, then reset mid-pulse and mid-count
    vcc = 1'b0;
    step(1, "vcc");
    chk("vcc.pinb", 32'(pinb_data), 32'h00);
    chk("vcc.pcif", 32'(pcif), 32'h0);
    step(1, "vcc");
    vcc = 1'b1;
    step(5, "vcc_back");
    chk("vcc_back.e5", 32'(pinb_data), 32'h00);
    step(1, "vcc_back");
    chk("vcc_back.e6", 32'(pinb_data), 32'h3C);
    async_reset("midpulse");
    @(negedge clk);
    rst_n = 1'b1;
    step(2, "midcount");
    async_reset("midcount");
    @(negedge clk);
    rst_n = 1'b1;
    step(5, "after_rst");
    chk("after_rst.e5", 32'(pinb_data), 32'h00);
    step(1, "after_rst");
    chk("after_rst.e6", 32'(pinb_data), 32'h3C);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(5) == 0) pin_raw[b] = ~pin_raw[b];
      if ($urandom_range(19) == 0) pcmsk = 4'($urandom);
      pcif_clr = ($urandom_range(7) == 0);
      vcc      = ($urandom_range(59) != 0);
      if (c % 157 == 100) begin
        async_reset("rand");
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pinb_input_conditioner.md
# pinb_input_conditioner

Input-conditioning stage that sits directly upstream of the tiny85 co-simulation model. It samples the four raw PB2..PB5 pad levels coming from the analog side, and synchronises and debounces each one. It presents the settled values as the 6-bit PINB word the model consumes, and raises a masked pin-change flag in the style of the ATtiny85 PCIF/PCMSK mechanism.

## Interface

Parameters:
- SYNC_STAGES, 2: synchroniser depth per pin; legal range ≥2.
- DEBOUNCE_CYCLES, 4: consecutive synchronised cycles a new level must hold before acceptance; legal range ≥1. Counter width is ceil(log2(DEBOUNCE_CYCLES+1)).

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- vcc, input, 1: supply-good. Low means all state is synchronously cleared and held at reset values.
- pin_raw, input, 4: raw pad levels; bit0=PB2, bit1=PB3, bit2=PB4, bit3=PB5.
- pcmsk, input, 4: per-pin change-interrupt enable, same bit order as pin_raw.
- pcif_clr, input, 1: single-cycle request to clear pcif.
- pinb_data, output, 6: bits[5:2] are the debounced PB5..PB2 levels; bits[1:0] are always 0. Numeric value equals PB2*4+PB3*8+PB4*16+PB5*32.
- pin_change, output, 4: one-cycle pulse per pin when its debounced level changes.
- pcif, output, 1: sticky pin-change flag.

## Operation

- Per pin, the datapath is: SYNC_STAGES flop chain → debounce counter → stable register.
- Debounce rule, evaluated each edge with vcc=1:
  - If the synchronised value equals the stable value, the counter goes to 0.
  - Otherwise the counter increments.
  - When the increment would reach DEBOUNCE_CYCLES, the stable value takes the synchronised value and the counter goes to 0.
- A glitch lasting fewer than DEBOUNCE_CYCLES synchronised cycles never changes the stable value. A reversal mid-count restarts the count from 0.
- pin_change[i] is registered and is 1 for exactly the cycle following the edge on which stable[i] updates. Otherwise it is 0.
- pcif:
  - Set on the same edge as any stable[i] update where pcmsk[i]=1. pcmsk is sampled on that edge.
  - Cleared by pcif_clr=1.
  - If set and clear happen on the same edge, set wins.
  - pcif_clr while pcif=0 has no effect.
- Unmasked pins still update pinb_data and pulse pin_change; they never touch pcif.
- Pins are fully independent. Simultaneous updates on several pins set pcif once and pulse every affected pin_change bit in the same cycle.
- vcc=0: sync chains, counters, stable values, pin_change and pcif are all cleared at the next edge and held there. When vcc returns to 1, the block starts from the cleared state, exactly as after reset.

## Timing

- Reset values (rst_n=0, effective immediately and independent of clk):
  - pinb_data=6'h00, pin_change=4'h0, pcif=0.
  - All synchroniser flops, counters and stable registers are 0.
- Latency: a pad change is present before rising edge 1 and held. The new stable value appears in pinb_data after edge SYNC_STAGES+DEBOUNCE_CYCLES, which is edge 6 with the defaults.
- pin_change and pcif rise after that same edge. pin_change falls after the next edge.
- DEBOUNCE_CYCLES=1: the stable value follows the synchronised value with one edge of latency, and there is no filtering.
- Steady-state high pad after reset release: it is accepted like any change, at edge SYNC_STAGES+DEBOUNCE_CYCLES after release. It produces a pin_change pulse and sets pcif if masked.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset asserted mid-count or mid-pulse: all state returns to reset values asynchronously. There is no partial acceptance.
- pcif_clr has one-edge latency: pcif reads 0 after the edge on which pcif_clr=1 is sampled, unless a set event happens on that same edge.
- No combinational path exists from any input to any output.

## Test plan

- Reset and steady low: pin_raw=4'h0, pcmsk=4'hF, 20 cycles after release → pinb_data=0, pin_change=0, pcif=0 throughout.
- Clean edge on PB3 with defaults: pin_raw=4'b0010 before edge 1 → pinb_data=6'h08 after edge 6. pin_change=4'b0010 for exactly cycle 6→7. pcif=1 after edge 6 with pcmsk[1]=1.
- Glitch rejection: PB4 high for 3 cycles, then low → pinb_data stays 0, no pin_change, pcif stays 0. A 4-cycle pulse on PB4 is accepted, giving pinb_data=6'h10.
- Masking and clear:
  - pcmsk=4'b0001, toggle PB5 → pinb_data bit5 follows, pin_change[3] pulses, pcif stays 0.
  - Then toggle PB2 with pcif_clr asserted on the same edge as the stable update → pcif=1 (set wins).
  - pcif_clr on the next edge → pcif=0.
- Simultaneous pins: pin_raw 4'h0→4'hF in one cycle → pinb_data=6'h3C after edge 6, pin_change=4'hF for one cycle, pcif=1.
- Power drop and reset mid-count: pinb_data=6'h3C, then vcc=0 for 2 cycles → all outputs 0 after the first edge. With vcc=1 and pads still 4'hF, pinb_data=6'h3C returns after 6 edges. Repeat, asserting rst_n=0 at count 2 → outputs 0 immediately, and a full 6-edge latency applies after release.
